// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 receiver and the matrix-driver bench.
package hub75_pkg;

    localparam int unsigned RGB_W = 6;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_STREAM
    } rx_state_t;

    // Bit order on the connector: {r1, g1, b1, r2, g2, b2}
    typedef struct packed {
        logic r1;
        logic g1;
        logic b1;
        logic r2;
        logic g2;
        logic b2;
    } hub_rgb_t;

endpackage

// File: rtl/hub75_rx_if.sv
// Pixel stream leaving the receiver: valid/ready handshake plus column, row and colour.
interface hub75_rx_if #(
    parameter int unsigned COL_BITS   = 7,
    parameter int unsigned MUX_LENGTH = 4
);

    logic                        pix_valid;
    logic                        pix_ready;
    logic [COL_BITS-1:0]         pix_col;
    logic [MUX_LENGTH-1:0]       pix_row;
    logic [hub75_pkg::RGB_W-1:0] pix_rgb;

    modport master (output pix_valid, output pix_col, output pix_row, output pix_rgb,
                    input pix_ready);
    modport slave  (input pix_valid, input pix_col, input pix_row, input pix_rgb,
                    output pix_ready);

endinterface

// File: rtl/hub75_sync.sv
// Two-flop synchronizer plus one history flop, with edge outputs taken from the
// synchronised level (s2) against its one-cycle-old copy (s3).
module hub75_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1, s2, s3;

    // Synchronizer chain; kept running regardless of the receiver enable
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: rebuilds latched rows from the panel pins and streams them
// out as pixels, and optionally measures each OE-low display window.
// Optional feature macro: HUB75_RX_OE_TIMER_EN (OE window timer and on_* outputs).
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int unsigned MATRIX_WIDTH      = 64,
    parameter int unsigned MUX_LENGTH        = 4,
    parameter int unsigned COL_BITS          = 7,
    parameter int unsigned WAIT_COUNT_LENGTH = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         hub_clk,
    input  logic                         hub_lat,
    input  logic                         hub_oe,
    input  logic [MUX_LENGTH-1:0]        hub_addr,
    input  logic [RGB_W-1:0]             hub_rgb,
    hub75_rx_if.master                   pix,
    output logic                         row_len_err,
    output logic                         row_drop,
    output logic                         on_valid,
    output logic [MUX_LENGTH-1:0]        on_addr,
    output logic [WAIT_COUNT_LENGTH-1:0] on_count
);

    localparam int unsigned DATA_W = MUX_LENGTH + RGB_W;
    localparam int unsigned IDX_W  = $clog2(MATRIX_WIDTH);
    localparam logic [COL_BITS-1:0] COL_FULL = COL_BITS'(MATRIX_WIDTH);
    localparam logic [COL_BITS-1:0] COL_OVER = COL_BITS'(MATRIX_WIDTH + 1);
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(MATRIX_WIDTH - 1);

    // Control lines: bit 0 = hub_clk, bit 1 = hub_lat, bit 2 = hub_oe
    logic [2:0]        ctrl_q, ctrl_rise, ctrl_fall;
    logic [DATA_W-1:0] data_q, unused_data_rise, unused_data_fall;
    logic              unused_ctrl;

    hub75_sync #(.WIDTH(3)) u_sync_ctrl (
        .clk  (clk),
        .rst  (rst),
        .d    ({hub_oe, hub_lat, hub_clk}),
        .q    (ctrl_q),
        .rise (ctrl_rise),
        .fall (ctrl_fall)
    );

    // Same depth as the control path, so data/address line up with the detected edge
    hub75_sync #(.WIDTH(DATA_W)) u_sync_data (
        .clk  (clk),
        .rst  (rst),
        .d    ({hub_addr, hub_rgb}),
        .q    (data_q),
        .rise (unused_data_rise),
        .fall (unused_data_fall)
    );

    logic                  clk_rise, lat_rise;
    logic [MUX_LENGTH-1:0] addr_s;
    logic [RGB_W-1:0]      rgb_s;

    assign clk_rise = enable & ctrl_rise[0];
    assign lat_rise = enable & ctrl_rise[1];
    assign addr_s   = data_q[DATA_W-1:RGB_W];
    assign rgb_s    = data_q[RGB_W-1:0];

    logic [COL_BITS-1:0] col_cnt_q;
    logic [RGB_W-1:0]    shift_buf [MATRIX_WIDTH];
    logic [RGB_W-1:0]    row_buf   [MATRIX_WIDTH];
    logic [IDX_W-1:0]    wr_idx;

    // A shift clock coincident with the latch belongs to the next row, so it lands in slot 0
    assign wr_idx = lat_rise ? '0 : col_cnt_q[IDX_W-1:0];

    // Column counter: saturates one past the row width so over-long rows are still flagged
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            col_cnt_q <= '0;
        end else if (lat_rise) begin
            col_cnt_q <= clk_rise ? COL_BITS'(1) : '0;
        end else if (clk_rise && col_cnt_q != COL_OVER) begin
            col_cnt_q <= col_cnt_q + COL_BITS'(1);
        end
    end

    // Shift buffer write; pixels beyond the row width are discarded
    always_ff @(posedge clk) begin
        if (!rst && clk_rise && (lat_rise || col_cnt_q < COL_FULL)) begin
            shift_buf[wr_idx] <= rgb_s;
        end
    end

    rx_state_t             state_q, state_d;
    logic [COL_BITS-1:0]   idx_q, idx_d;
    logic [MUX_LENGTH-1:0] row_addr_q;
    logic                  streaming, handshake, last_beat, accept, err_d, drop_d;

    assign streaming = (state_q == ST_STREAM);
    assign handshake = streaming & pix.pix_ready;
    assign last_beat = handshake & (idx_q == COL_LAST);

    // Streamer next state; a latch landing on the final handshake starts the next row
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        accept  = 1'b0;
        err_d   = 1'b0;
        drop_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_STREAM: begin
                if (handshake) begin
                    idx_d = idx_q + COL_BITS'(1);
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        if (lat_rise) begin
            err_d = (col_cnt_q != COL_FULL);
            if (!streaming || last_beat) begin
                accept  = 1'b1;
                state_d = ST_STREAM;
                idx_d   = '0;
            end else begin
                drop_d = 1'b1;
            end
        end
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            accept  = 1'b0;
            err_d   = 1'b0;
            drop_d  = 1'b0;
        end
    end

    // Streamer state, row address and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            row_addr_q  <= '0;
            row_len_err <= 1'b0;
            row_drop    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_len_err <= err_d;
            row_drop    <= drop_d;
            if (accept) begin
                row_addr_q <= addr_s;
            end
        end
    end

    // Row buffer snapshot on an accepted latch
    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf <= shift_buf;
        end
    end

    assign pix.pix_valid = streaming;
    assign pix.pix_col   = streaming ? idx_q : '0;
    assign pix.pix_row   = streaming ? row_addr_q : '0;
    assign pix.pix_rgb   = streaming ? row_buf[idx_q[IDX_W-1:0]] : '0;

`ifdef HUB75_RX_OE_TIMER_EN
    logic                         in_win_q;
    logic [WAIT_COUNT_LENGTH-1:0] win_cnt_q;

    // OE window timer; only windows whose falling edge was seen are reported, which hides
    // the apparent low-to-high OE transition right after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            in_win_q  <= 1'b0;
            win_cnt_q <= '0;
            on_valid  <= 1'b0;
            on_addr   <= '0;
            on_count  <= '0;
        end else if (!enable) begin
            in_win_q  <= 1'b0;
            win_cnt_q <= '0;
            on_valid  <= 1'b0;
        end else begin
            on_valid <= 1'b0;
            if (ctrl_fall[2]) begin
                in_win_q  <= 1'b1;
                win_cnt_q <= WAIT_COUNT_LENGTH'(1);
            end else if (ctrl_rise[2]) begin
                in_win_q <= 1'b0;
                if (in_win_q) begin
                    on_valid <= 1'b1;
                    on_count <= win_cnt_q;
                    on_addr  <= addr_s;
                end
            end else if (in_win_q && win_cnt_q != '1) begin
                win_cnt_q <= win_cnt_q + WAIT_COUNT_LENGTH'(1);
            end
        end
    end

    assign unused_ctrl = ^{ctrl_q, ctrl_fall[1:0]};
`else
    assign on_valid    = 1'b0;
    assign on_addr     = '0;
    assign on_count    = '0;
    assign unused_ctrl = ^{ctrl_q, ctrl_fall, ctrl_rise[2]};
`endif

endmodule
